// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: shared state encoding, legal phase codes and their indices.
package phase_seq_pkg;
    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
    localparam logic [2:0] CODE_0 = 3'b000;
    localparam logic [2:0] CODE_1 = 3'b001;
    localparam logic [2:0] CODE_2 = 3'b010;
    localparam logic [2:0] CODE_3 = 3'b100;
    localparam logic [1:0] IDX_0 = 2'd0;
    localparam logic [1:0] IDX_1 = 2'd1;
    localparam logic [1:0] IDX_2 = 2'd2;
    localparam logic [1:0] IDX_3 = 2'd3;
    function automatic logic code_legal(input logic [2:0] code);
        return code == CODE_0 || code == CODE_1 || code == CODE_2 || code == CODE_3;
    endfunction
    function automatic logic [1:0] code_idx(input logic [2:0] code);
        return code == CODE_1 ? IDX_1 : code == CODE_2 ? IDX_2 : code == CODE_3 ? IDX_3 : IDX_0;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + WIDTH'(1);
    end
endmodule

// File: rtl/phase_seq_checker.sv
// phase_seq_checker: checks a one-hot-ish 3-bit phase rotation 000->001->010->100,
// locks after LOCK_COUNT legal transitions and counts errors and locked wraps.
module phase_seq_checker
    import phase_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       y_in,
    input  logic             y_valid,
    input  logic             clr_cnt,
    output logic [1:0]       phase_idx,
    output logic             lock,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);
    state_t     state, state_nxt;
    logic [3:0] run, run_nxt;
    logic [1:0] idx_nxt, y_idx;
    logic       legal, step_ok, err_nxt, wrap_nxt;

    // phase_idx doubles as the stored previous sample: it always holds the last legal code
    always_comb begin
        y_idx     = code_idx(y_in);
        legal     = code_legal(y_in);
        step_ok   = legal && state != IDLE && y_idx == phase_idx + 2'd1;
        state_nxt = state;
        run_nxt   = run;
        idx_nxt   = phase_idx;
        err_nxt   = 1'b0;
        wrap_nxt  = 1'b0;
        if (y_valid) begin
            idx_nxt = legal ? y_idx : phase_idx;
            if (state == IDLE) begin
                state_nxt = legal ? ACQUIRE : IDLE;
                run_nxt   = 4'd0;
                err_nxt   = !legal;
            end else if (step_ok) begin
                wrap_nxt = state == LOCKED && phase_idx == IDX_3;
                if (state == ACQUIRE) begin
                    run_nxt   = run + 4'd1;
                    state_nxt = run_nxt == 4'(LOCK_COUNT) ? LOCKED : ACQUIRE;
                end
            end else begin
                err_nxt   = 1'b1;
                run_nxt   = 4'd0;
                state_nxt = legal ? ACQUIRE : IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            run        <= 4'd0;
            phase_idx  <= IDX_0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            run        <= run_nxt;
            phase_idx  <= idx_nxt;
            err_pulse  <= err_nxt;
            wrap_pulse <= wrap_nxt;
        end
    end

    assign lock = state == LOCKED;

    sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_nxt),
        .clr   (clr_cnt),
        .count (err_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_nxt),
        .clr   (clr_cnt),
        .count (wrap_count)
    );
endmodule

// File: tb/tb_phase_seq_checker.sv
// tb_phase_seq_checker: directed scoreboard bench for phase_seq_checker, plus a
// CNT_W=2 instance for counter saturation and clear priority.
module tb_phase_seq_checker;
    localparam int LC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1, y_valid = 1'b0, clr_cnt = 1'b0;
    logic [2:0] y_in = 3'b000;
    logic [1:0] phase_idx;
    logic       lock, err_pulse, wrap_pulse;
    logic [7:0] err_count, wrap_count;

    logic       y_valid2 = 1'b0, clr_cnt2 = 1'b0;
    logic [2:0] y_in2 = 3'b000;
    logic [1:0] phase_idx2, err_count2, wrap_count2;
    logic       lock2, err_pulse2, wrap_pulse2;

    always #5 clk = ~clk;

    phase_seq_checker #(.LOCK_COUNT(LC), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .y_in(y_in), .y_valid(y_valid), .clr_cnt(clr_cnt),
        .phase_idx(phase_idx), .lock(lock), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
        .err_count(err_count), .wrap_count(wrap_count)
    );

    phase_seq_checker #(.LOCK_COUNT(LC), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .y_in(y_in2), .y_valid(y_valid2), .clr_cnt(clr_cnt2),
        .phase_idx(phase_idx2), .lock(lock2), .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2),
        .err_count(err_count2), .wrap_count(wrap_count2)
    );

    typedef struct {
        logic [1:0] idx;
        logic       lock, err, wrap;
        logic [7:0] ec, wc;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0, n_fail = 0;
    int         m_state, m_run, m_idx;
    logic [7:0] m_ec, m_wc;

    function automatic int idx_of(input logic [2:0] y);
        case (y)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            3'b100:  return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model state: 0 idle, 1 acquire, 2 locked; m_idx is the last legal index.
    task automatic step(input logic r, input logic v, input logic [2:0] y, input logic c, input string tag);
        exp_t e;
        int   id;
        @(negedge clk);
        reset = r; y_valid = v; y_in = y; clr_cnt = c;
        e.err = 1'b0; e.wrap = 1'b0;
        id = idx_of(y);
        if (r) begin
            m_state = 0; m_run = 0; m_idx = 0; m_ec = 8'd0; m_wc = 8'd0;
        end else begin
            if (v) begin
                if (m_state == 0) begin
                    if (id >= 0) begin m_state = 1; m_run = 0; m_idx = id; end
                    else e.err = 1'b1;
                end else if (id >= 0 && id == (m_idx + 1) % 4) begin
                    if (m_state == 2) e.wrap = (id == 0);
                    else begin m_run++; if (m_run == LC) m_state = 2; end
                    m_idx = id;
                end else begin
                    e.err = 1'b1; m_run = 0;
                    if (id >= 0) begin m_state = 1; m_idx = id; end
                    else m_state = 0;
                end
            end
            if (c) begin m_ec = 8'd0; m_wc = 8'd0; end
            else begin
                if (e.err && m_ec != 8'hff) m_ec++;
                if (e.wrap && m_wc != 8'hff) m_wc++;
            end
        end
        e.idx = m_idx[1:0]; e.lock = (m_state == 2); e.ec = m_ec; e.wc = m_wc;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".idx"},  32'(phase_idx),  32'(e.idx));
        chk({tag, ".lock"}, 32'(lock),       32'(e.lock));
        chk({tag, ".err"},  32'(err_pulse),  32'(e.err));
        chk({tag, ".wrap"}, 32'(wrap_pulse), 32'(e.wrap));
        chk({tag, ".ec"},   32'(err_count),  32'(e.ec));
        chk({tag, ".wc"},   32'(wrap_count), 32'(e.wc));
    endtask

    initial begin
        step(1, 0, 3'b000, 0, "rst0");
        step(1, 1, 3'b011, 1, "rst1");
        // acquire and lock
        step(0, 1, 3'b000, 0, "acq0");
        step(0, 1, 3'b001, 0, "acq1");
        step(0, 1, 3'b010, 0, "acq2");
        step(0, 1, 3'b100, 0, "acq3");
        step(0, 1, 3'b000, 0, "acq4");
        chk("locked", 32'(lock), 32'(1));
        // locked rotation with one wrap
        step(0, 1, 3'b001, 0, "rot1");
        step(0, 1, 3'b010, 0, "rot2");
        step(0, 1, 3'b100, 0, "rot3");
        step(0, 1, 3'b000, 0, "wrap");
        // illegal code while locked -> IDLE; 000 then must be accepted silently
        step(0, 1, 3'b001, 0, "at1");
        step(0, 1, 3'b011, 0, "bad_code");
        step(0, 1, 3'b000, 0, "idle_acc");
        step(0, 1, 3'b001, 0, "re1");
        step(0, 1, 3'b010, 0, "re2");
        step(0, 1, 3'b100, 0, "re3");
        step(0, 1, 3'b000, 0, "re4");
        step(0, 1, 3'b001, 0, "lk1");
        // skip while locked -> ACQUIRE, then relock
        step(0, 1, 3'b100, 0, "skip");
        step(0, 1, 3'b000, 0, "sk_a");
        step(0, 1, 3'b001, 0, "sk_b");
        step(0, 1, 3'b010, 0, "sk_c");
        step(0, 1, 3'b100, 0, "sk_d");
        step(0, 1, 3'b100, 0, "repeat");
        step(0, 1, 3'b000, 0, "rp_a");
        step(0, 1, 3'b001, 0, "rp_b");
        step(0, 1, 3'b010, 0, "rp_c");
        step(0, 1, 3'b100, 0, "rp_d");
        step(0, 1, 3'b000, 0, "wrap2");
        step(0, 1, 3'b001, 1, "clr");
        // stall then reset mid-lock
        step(0, 0, 3'b111, 0, "stall1");
        step(0, 0, 3'b011, 0, "stall2");
        step(0, 0, 3'b111, 0, "stall3");
        step(0, 1, 3'b010, 0, "post_stall");
        step(1, 1, 3'b011, 1, "rst_mid");
        step(0, 0, 3'b000, 0, "after_rst");
        chk("sb_empty", 32'(q.size()), 32'(0));
        // CNT_W=2 saturation and clear priority
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            y_in2 = 3'b011; y_valid2 = 1'b1; clr_cnt2 = 1'b0;
            @(posedge clk);
            #1;
            chk("sat.ec", 32'(err_count2), 32'(k > 3 ? 3 : k));
            chk("sat.err", 32'(err_pulse2), 32'(1));
        end
        @(negedge clk);
        clr_cnt2 = 1'b1;
        @(posedge clk);
        #1;
        chk("clr7.ec", 32'(err_count2), 32'(0));
        chk("clr7.err", 32'(err_pulse2), 32'(1));
        @(negedge clk);
        y_valid2 = 1'b0; clr_cnt2 = 1'b0;
        @(posedge clk);
        #1;
        chk("idle2.err", 32'(err_pulse2), 32'(0));
        chk("idle2.ec", 32'(err_count2), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/phase_seq_checker.md
PHASE_SEQ_CHECKER -- requirements
Module: phase_seq_checker

Interface
REQ-001 Parameter: LOCK_COUNT, 4, number of consecutive legal transitions required to assert lock (legal range 1..15).
REQ-002 Parameter: CNT_W, 8, width of the error and wrap counters.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: y_in  input  3  phase code from the upstream phase generator.
REQ-006 Port: y_valid  input  1  y_in is sampled only on edges where y_valid=1.
REQ-007 Port: clr_cnt  input  1  synchronous clear of err_count and wrap_count.
REQ-008 Port: phase_idx  output  2  decoded index of the last legal sample.
REQ-009 Port: lock  output  1  high while in state LOCKED.
REQ-010 Port: err_pulse  output  1  one-cycle pulse per detected error.
REQ-011 Port: wrap_pulse  output  1  one-cycle pulse per locked wrap 100->000.
REQ-012 Port: err_count  output  CNT_W  saturating error count.
REQ-013 Port: wrap_count  output  CNT_W  saturating wrap count.

Function
REQ-014 Legal codes and indices: 000->0, 001->1, 010->2, 100->3; every other code is illegal.
REQ-015 Legal successor relation: 000->001, 001->010, 010->100, 100->000; any other pair, including repeats, is an illegal transition.
REQ-016 All outputs are registered; the response to a sample taken at edge N is visible after edge N (latency 1).
REQ-017 y_valid=0: no sample is taken, state, counters and phase_idx hold, err_pulse and wrap_pulse are 0.
REQ-018 States: IDLE (no previous sample), ACQUIRE (counting legal transitions), LOCKED.
REQ-019 IDLE + legal sample: store sample, go to ACQUIRE with run count 0; IDLE + illegal code: error, stay IDLE.
REQ-020 ACQUIRE + legal transition: run count +1; go to LOCKED when the count reaches LOCK_COUNT.
REQ-021 ACQUIRE or LOCKED + illegal code or illegal transition: error, run count 0, state ACQUIRE if code legal (sample stored), IDLE if code illegal.
REQ-022 An illegal code is always also an illegal transition; this counts as exactly one error.
REQ-023 Error: err_pulse=1 for one cycle; err_count +1; phase_idx holds its last legal value.
REQ-024 LOCKED + legal transition 100->000: wrap_pulse=1 for one cycle; wrap_count +1.
REQ-025 Counters saturate at all-ones and never wrap.
REQ-026 clr_cnt=1 sets both counters to 0 at the next edge; clear wins over a coincident increment; pulses are unaffected by clr_cnt.
REQ-027 phase_idx updates on every legal sample, in any state.

Reset
REQ-028 reset=1 at an edge: state IDLE, run count 0, phase_idx 0, lock 0, err_pulse 0, wrap_pulse 0, err_count 0, wrap_count 0.
REQ-029 reset overrides y_valid and clr_cnt, including mid-operation in LOCKED.

Structure
REQ-030 Shared package phase_seq_pkg holds the state enum and the four legal code constants with their indices.
REQ-031 One sub-module, sat_counter (parameter width, inputs inc/clr), instantiated for err_count and wrap_count.

Verification (LOCK_COUNT=4, CNT_W=8 unless stated)
REQ-032 Reset; feed 000,001,010,100,000 with y_valid=1 -> lock=1 after the edge that samples the 5th value; err_count=0; wrap_count=0.
REQ-033 Locked; feed 001,010,100,000 -> wrap_pulse exactly one cycle after the 000 sample; wrap_count=1; phase_idx sequence 1,2,3,0.
REQ-034 Locked at 001; inject 011 -> err_pulse one cycle, err_count=1, lock=0, state IDLE, phase_idx stays 1.
REQ-035 Locked at 001; inject 100 (skip) -> one error, state ACQUIRE; four further legal transitions -> lock=1 again.
REQ-036 CNT_W=2: six illegal samples -> err_count saturates at 3; clr_cnt together with a 7th error -> err_count=0, err_pulse=1.
REQ-037 y_valid low for 3 cycles while locked, then reset mid-lock -> outputs hold during the stall, then all equal reset values one edge after reset.
